// File: rtl/sad_pkg.sv
// Shared types and sizing for the block-matching SAD cost path.
// Provides default widths, accumulator sizing helper and output FSM states.
package sad_pkg;

   localparam int SAD_DATA_W    = 9;
   localparam int SAD_BLOCK_LEN = 16;

   // Accumulator width that can never overflow for a full block.
   function automatic int sad_acc_w(input int data_w, input int block_len);
      return data_w + $clog2(block_len);
   endfunction

   typedef enum logic {
      SAD_ACCUM = 1'b0,
      SAD_FULL  = 1'b1
   } sad_state_e;

endpackage

// File: rtl/sad_out_reg.sv
// Result holding register with valid/ready and load-while-draining.
// Ports: clk, rst_n, load_i/load_data_i (new result), out_valid_o/out_ready_i/out_data_o.
module sad_out_reg
   import sad_pkg::*;
#(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   sad_state_e   state_q;
   logic         valid_q;
   logic [W-1:0] data_q;

   // The producer only loads while the slot is empty or draining this
   // cycle, so a load in FULL always replaces a consumed result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SAD_ACCUM;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         unique case (state_q)
            SAD_ACCUM: begin
               if (load_i) begin
                  state_q <= SAD_FULL;
                  valid_q <= 1'b1;
                  data_q  <= load_data_i;
               end
            end
            SAD_FULL: begin
               if (load_i) begin
                  data_q <= load_data_i;
               end else if (out_ready_i) begin
                  state_q <= SAD_ACCUM;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= SAD_ACCUM;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/sad_accum.sv
// Streaming block SAD accumulator fed by abs_diff, with valid/ready output.
// Ports: clk, rst_n, clear, in_valid/in_ready/in_diff, out_valid/out_ready/out_sad, out_blk_cnt.
module sad_accum
   import sad_pkg::*;
#(
   parameter int DATA_W    = SAD_DATA_W,
   parameter int BLOCK_LEN = SAD_BLOCK_LEN,
   parameter int ACC_W     = sad_acc_w(DATA_W, BLOCK_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_diff,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sad,
   output logic [7:0]        out_blk_cnt
);

   localparam int CNT_W = $clog2(BLOCK_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       blk_q, blk_d;
   logic [ACC_W-1:0] sum;
   logic             accept;
   logic             last;

   // Stall only while a finished result sits unconsumed.
   assign in_ready = ~(out_valid & ~out_ready);
   assign accept   = in_valid & in_ready;
   assign last     = accept & ~clear & (cnt_q == CNT_LAST);
   assign sum      = acc_q + ACC_W'(in_diff);

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      blk_d = blk_q;
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         acc_d = last ? '0 : sum;
         cnt_d = cnt_q + 1'b1;
      end
      if (last) begin
         blk_d = blk_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         blk_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         blk_q <= blk_d;
      end
   end

   sad_out_reg #(
      .W(ACC_W)
   ) u_out (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (last),
      .load_data_i(sum),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_sad)
   );

   assign out_blk_cnt = blk_q;

endmodule
